// File: rtl/simon_sequence_player.sv
// simon_sequence_player: stores a short direction sequence and replays it on
// the four Simon arrow pads via a valid/ready pixel-block plot request.
// Optional build macro SIMON_TONE_EN adds tone_code, which carries the
// direction of the pad being held lit.
module simon_sequence_player #(
  parameter int          SEQ_DEPTH   = 16,
  parameter int          HOLD_CYCLES = 25000000,
  parameter int          GAP_CYCLES  = 12500000,
  parameter logic [2:0]  IDLE_COLOR  = 3'b111,
  parameter logic [2:0]  LIT_COLOR   = 3'b010,
  localparam int         CW          = $clog2(SEQ_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          seq_clear,
  input  logic          seq_wr_en,
  input  logic [1:0]    seq_wr_dir,
  input  logic          begin_signal,
  input  logic          stop,
  input  logic          plot_ready,
  output logic          plot_valid,
  output logic [7:0]    out_x,
  output logic [6:0]    out_y,
  output logic [2:0]    out_color,
  output logic [CW-1:0] seq_count,
  output logic          seq_full,
  output logic          busy,
`ifdef SIMON_TONE_EN
  output logic [2:0]    tone_code,
`endif
  output logic          done
);

  // state     | meaning
  // S_INIT    | draw the four pads in idle colour (up, down, left, right)
  // S_IDLE    | accept sequence edits and begin_signal
  // S_LIGHT   | request current pad in lit colour
  // S_HOLD    | keep pad lit for HOLD_CYCLES unstopped clocks
  // S_UNLIGHT | request current pad back in idle colour
  // S_GAP     | wait GAP_CYCLES unstopped clocks before next step
  // S_DONE    | one-cycle done pulse
  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LIGHT, S_HOLD, S_UNLIGHT, S_GAP, S_DONE
  } state_t;

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNTW = $clog2(MAXC + 1);
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_CYCLES - 1);
  localparam logic [CNTW-1:0] GAP_LAST  = CNTW'(GAP_CYCLES - 1);
  // Memory is sized to the full index range so a CW-bit index never overruns.
  localparam int MEM_N = 1 << CW;
  localparam logic [CW-1:0] DEPTH_C = CW'(SEQ_DEPTH);

  state_t          state;
  logic [1:0]      mem [MEM_N];
  logic [1:0]      init_idx;
  logic [CW-1:0]   step;
  logic [CNTW-1:0] cnt;

  logic [1:0]      init_dir;
  logic [CW-1:0]   step_nx;
  logic [1:0]      issue_dir;
  logic            wr_ok;

  function automatic logic [7:0] pad_x(input logic [1:0] d);
    case (d)
      2'b00:   pad_x = 8'd78;
      2'b01:   pad_x = 8'd78;
      2'b10:   pad_x = 8'd82;
      default: pad_x = 8'd74;
    endcase
  endfunction

  function automatic logic [6:0] pad_y(input logic [1:0] d);
    case (d)
      2'b00:   pad_y = 7'd54;
      2'b01:   pad_y = 7'd62;
      default: pad_y = 7'd58;
    endcase
  endfunction

  // Init order up, down, left, right is the Gray sequence 00,01,11,10.
  assign init_dir  = {init_idx[1], init_idx[1] ^ init_idx[0]};
  assign step_nx   = step + 1'b1;
  assign issue_dir = (state == S_IDLE) ? mem[0] : mem[step_nx];
  assign seq_full  = (seq_count == DEPTH_C);
  assign wr_ok     = (state == S_IDLE) && !seq_clear && seq_wr_en && !seq_full;

  // Sequence storage; contents are don't-care beyond seq_count so no reset.
  always_ff @(posedge clock) begin
    if (reset_n && wr_ok) begin
      mem[seq_count] <= seq_wr_dir;
    end
  end

  // Playback controller with registered plot request and status outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= S_INIT;
      init_idx   <= '0;
      step       <= '0;
      cnt        <= '0;
      seq_count  <= '0;
      plot_valid <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_color  <= '0;
      done       <= 1'b0;
      busy       <= 1'b1;
`ifdef SIMON_TONE_EN
      tone_code  <= 3'b000;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_INIT: begin
          if (!plot_valid) begin
            plot_valid <= 1'b1;
            out_x      <= pad_x(init_dir);
            out_y      <= pad_y(init_dir);
            out_color  <= IDLE_COLOR;
          end else if (plot_ready) begin
            plot_valid <= 1'b0;
            init_idx   <= init_idx + 1'b1;
            if (init_idx == 2'd3) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        S_IDLE: begin
          if (seq_clear) begin
            seq_count <= '0;
          end else if (wr_ok) begin
            seq_count <= seq_count + 1'b1;
          end
          if (begin_signal) begin
            step <= '0;
            busy <= 1'b1;
            if (seq_count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state      <= S_LIGHT;
              plot_valid <= 1'b1;
              out_x      <= pad_x(issue_dir);
              out_y      <= pad_y(issue_dir);
              out_color  <= LIT_COLOR;
            end
          end
        end

        S_LIGHT: begin
          if (plot_ready) begin
            plot_valid <= 1'b0;
            cnt        <= '0;
            state      <= S_HOLD;
`ifdef SIMON_TONE_EN
            tone_code  <= {1'b1, mem[step]};
`endif
          end
        end

        S_HOLD: begin
          if (!stop) begin
            if (cnt == HOLD_LAST) begin
              state      <= S_UNLIGHT;
              plot_valid <= 1'b1;
              out_color  <= IDLE_COLOR;
`ifdef SIMON_TONE_EN
              tone_code  <= 3'b000;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_UNLIGHT: begin
          if (plot_ready) begin
            plot_valid <= 1'b0;
            cnt        <= '0;
            state      <= S_GAP;
          end
        end

        S_GAP: begin
          if (!stop) begin
            if (cnt == GAP_LAST) begin
              if (step == seq_count - 1'b1) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                step       <= step_nx;
                state      <= S_LIGHT;
                plot_valid <= 1'b1;
                out_x      <= pad_x(issue_dir);
                out_y      <= pad_y(issue_dir);
                out_color  <= LIT_COLOR;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_sequence_player.sv
// Bench for simon_sequence_player: directed steps with random sequences,
// checked against a queue-based model of the pad plots and their timing.
module tb_simon_sequence_player;
  localparam int DEPTH = 6;
  localparam int HOLD  = 4;
  localparam int GAP   = 2;
  localparam logic [2:0] IDLE_C = 3'b111;
  localparam logic [2:0] LIT_C  = 3'b010;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          seq_clear = 1'b0;
  logic          seq_wr_en = 1'b0;
  logic [1:0]    seq_wr_dir = 2'b00;
  logic          begin_signal = 1'b0;
  logic          stop = 1'b0;
  logic          plot_ready = 1'b1;
  logic          plot_valid;
  logic [7:0]    out_x;
  logic [6:0]    out_y;
  logic [2:0]    out_color;
  logic [CW-1:0] seq_count;
  logic          seq_full;
  logic          busy;
  logic          done;
`ifdef SIMON_TONE_EN
  logic [2:0]    tone_code;
  logic [1:0]    d0;
`endif

  simon_sequence_player #(
    .SEQ_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
    .IDLE_COLOR(IDLE_C), .LIT_COLOR(LIT_C)
  ) dut (
    .clock(clock), .reset_n(reset_n), .seq_clear(seq_clear),
    .seq_wr_en(seq_wr_en), .seq_wr_dir(seq_wr_dir),
    .begin_signal(begin_signal), .stop(stop), .plot_ready(plot_ready),
    .plot_valid(plot_valid), .out_x(out_x), .out_y(out_y),
    .out_color(out_color), .seq_count(seq_count), .seq_full(seq_full),
    .busy(busy),
`ifdef SIMON_TONE_EN
    .tone_code(tone_code),
`endif
    .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
    int c;
    int cyc;
  } xfer_t;

  xfer_t xq[$];
  int    rq[$];
  int    cyc = 0;
  int    done_cnt = 0;
  logic  pv_d = 1'b0;

  // Records accepted plots, request rise edges and done pulses.
  always @(posedge clock) begin
    if (reset_n) begin
      if (plot_valid && plot_ready)
        xq.push_back('{int'(out_x), int'(out_y), int'(out_color), cyc});
      if (plot_valid && !pv_d) rq.push_back(cyc);
      if (done) done_cnt++;
    end
    pv_d = plot_valid;
    cyc++;
  end

  int total = 0;
  int bad = 0;
  int mq[$];
  int xb, rb, db;

  function automatic int px(input int d);
    case (d)
      0: return 78;
      1: return 78;
      2: return 82;
      default: return 74;
    endcase
  endfunction

  function automatic int py(input int d);
    case (d)
      0: return 54;
      1: return 62;
      default: return 58;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [1:0] d);
    seq_wr_dir = d;
    seq_wr_en  = 1'b1;
    tick();
    seq_wr_en  = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(int'(d));
  endtask

  task automatic clr();
    seq_clear = 1'b1;
    tick();
    seq_clear = 1'b0;
    mq.delete();
  endtask

  task automatic go();
    begin_signal = 1'b1;
    tick();
    begin_signal = 1'b0;
  endtask

  task automatic mark();
    xb = xq.size();
    rb = rq.size();
    db = done_cnt;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int k = 0; k < budget && busy !== 1'b0; k++) tick();
    chk($sformatf("%s idle_reached", tag), busy, 0);
  endtask

  task automatic check_init_draw(input string tag);
    int ord[4] = '{0, 1, 3, 2};
    chk($sformatf("%s init_plots", tag), xq.size() - xb, 4);
    if (xq.size() - xb == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s init%0d_x", tag, i), xq[xb+i].x, px(ord[i]));
        chk($sformatf("%s init%0d_y", tag, i), xq[xb+i].y, py(ord[i]));
        chk($sformatf("%s init%0d_c", tag, i), xq[xb+i].c, IDLE_C);
      end
    end
  endtask

  task automatic verify_play(input string tag, input int stop_extra);
    int n;
    int hold;
    int gap;
    n = mq.size();
    chk($sformatf("%s plots", tag), xq.size() - xb, 2 * n);
    chk($sformatf("%s rises", tag), rq.size() - rb, 2 * n);
    chk($sformatf("%s done_pulses", tag), done_cnt - db, 1);
    chk($sformatf("%s seq_count", tag), seq_count, n);
    if (xq.size() - xb == 2 * n && rq.size() - rb == 2 * n) begin
      for (int k = 0; k < n; k++) begin
        chk($sformatf("%s s%0d lit_x", tag, k), xq[xb+2*k].x, px(mq[k]));
        chk($sformatf("%s s%0d lit_y", tag, k), xq[xb+2*k].y, py(mq[k]));
        chk($sformatf("%s s%0d lit_c", tag, k), xq[xb+2*k].c, LIT_C);
        chk($sformatf("%s s%0d unl_x", tag, k), xq[xb+2*k+1].x, px(mq[k]));
        chk($sformatf("%s s%0d unl_y", tag, k), xq[xb+2*k+1].y, py(mq[k]));
        chk($sformatf("%s s%0d unl_c", tag, k), xq[xb+2*k+1].c, IDLE_C);
        hold = rq[rb+2*k+1] - xq[xb+2*k].cyc - 1;
        chk($sformatf("%s s%0d hold", tag, k), hold, HOLD + ((k == 0) ? stop_extra : 0));
        if (k < n - 1) begin
          gap = rq[rb+2*k+2] - xq[xb+2*k+1].cyc - 1;
          chk($sformatf("%s s%0d gap", tag, k), gap, GAP);
        end
      end
    end
  endtask

  initial begin
    int n;
    int k;
    int d;

    // reset with plot_ready high
    reset_n = 1'b0;
    plot_ready = 1'b1;
    tick(3);
    chk("rst plot_valid", plot_valid, 0);
    chk("rst out_x", out_x, 0);
    chk("rst out_y", out_y, 0);
    chk("rst out_color", out_color, 0);
    chk("rst done", done, 0);
    chk("rst busy", busy, 1);
    chk("rst seq_count", seq_count, 0);
`ifdef SIMON_TONE_EN
    chk("rst tone", tone_code, 0);
`endif
    mark();
    reset_n = 1'b1;
    wait_idle("init", 60);
    check_init_draw("init");

    // directed sequence up, left, right
    clr();
    wr(2'b00);
    wr(2'b11);
    wr(2'b10);
    chk("dir seq_count", seq_count, 3);
    mark();
    go();
    wait_idle("dir", 3 * (HOLD + GAP + 8) + 20);
    tick(3);
    verify_play("dir", 0);

    // random sequences
    for (int it = 0; it < 3; it++) begin
      clr();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) wr(2'($urandom_range(0, 3)));
      chk($sformatf("rnd%0d seq_count", it), seq_count, n);
      mark();
      go();
      wait_idle($sformatf("rnd%0d", it), n * (HOLD + GAP + 8) + 20);
      tick(3);
      verify_play($sformatf("rnd%0d", it), 0);
    end

    // overfill: extra writes are dropped
    clr();
    for (int i = 0; i < DEPTH + 2; i++) wr(2'($urandom_range(0, 3)));
    chk("full seq_count", seq_count, DEPTH);
    chk("full seq_full", seq_full, 1);
    mark();
    go();
    wait_idle("full", DEPTH * (HOLD + GAP + 8) + 20);
    tick(3);
    verify_play("full", 0);

    // empty sequence: immediate done, no plots
    clr();
    chk("empty seq_count", seq_count, 0);
    chk("empty seq_full", seq_full, 0);
    mark();
    go();
    chk("empty done_hi", done, 1);
    tick();
    chk("empty done_lo", done, 0);
    chk("empty busy", busy, 0);
    tick(5);
    chk("empty plots", xq.size() - xb, 0);
    chk("empty done_pulses", done_cnt - db, 1);

    // backpressure on the lit request
    clr();
    wr(2'($urandom_range(0, 3)));
    d = mq[0];
    plot_ready = 1'b0;
    mark();
    go();
    for (k = 0; k < 5 && plot_valid !== 1'b1; k++) tick();
    chk("bp request_seen", plot_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp c%0d valid", i), plot_valid, 1);
      chk($sformatf("bp c%0d x", i), out_x, px(d));
      chk($sformatf("bp c%0d y", i), out_y, py(d));
      chk($sformatf("bp c%0d color", i), out_color, LIT_C);
      tick();
    end
    chk("bp no_transfer", xq.size() - xb, 0);
    plot_ready = 1'b1;
    wait_idle("bp", HOLD + GAP + 30);
    tick(3);
    verify_play("bp", 0);

    // stop for 5 cycles during the hold
    clr();
    wr(2'($urandom_range(0, 3)));
    mark();
    go();
    for (k = 0; k < 20 && xq.size() - xb < 1; k++) tick();
    chk("stop lit_accepted", xq.size() - xb, 1);
    stop = 1'b1;
    tick(5);
    stop = 1'b0;
    wait_idle("stop", HOLD + GAP + 30);
    tick(3);
    verify_play("stop", 5);

    // reset during the hold
    clr();
    wr(2'($urandom_range(0, 3)));
    wr(2'($urandom_range(0, 3)));
    mark();
    go();
    for (k = 0; k < 20 && xq.size() - xb < 1; k++) tick();
    chk("rsthold lit_accepted", xq.size() - xb, 1);
    tick();
`ifdef SIMON_TONE_EN
    d0 = 2'(mq[0]);
    chk("rsthold tone_on", tone_code, {1'b1, d0});
`endif
    chk("rsthold busy_before", busy, 1);
    reset_n = 1'b0;
    tick();
    mq.delete();
    chk("rsthold plot_valid", plot_valid, 0);
    chk("rsthold seq_count", seq_count, 0);
    chk("rsthold busy", busy, 1);
`ifdef SIMON_TONE_EN
    chk("rsthold tone_off", tone_code, 0);
`endif
    mark();
    reset_n = 1'b1;
    wait_idle("redraw", 60);
    check_init_draw("redraw");
    chk("redraw seq_count", seq_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simon_sequence_player.md
Name: simon_sequence_player

Overview:
- Parametrised playback engine for the Simon Says display.
- Stores a direction sequence of up to SEQ_DEPTH entries and draws the four arrow pads in idle colour.
- On begin_signal, plays the sequence back: lights each pad for HOLD_CYCLES, restores it, then waits GAP_CYCLES.
- Drives the VGA plotter through a valid/ready pixel-block request interface.

Parameters:
- SEQ_DEPTH, 16, maximum sequence entries (>=1).
- HOLD_CYCLES, 25000000, clocks a pad stays lit after its lit plot is accepted (>=1).
- GAP_CYCLES, 12500000, clocks between the unlit plot being accepted and the next step (>=1).
- IDLE_COLOR, 3'b111, pad colour when not lit.
- LIT_COLOR, 3'b010, pad colour when lit.
- CW, $clog2(SEQ_DEPTH+1), count width (derived localparam).

Ports:
- clock, in, 1, system clock; all logic on the rising edge.
- reset_n, in, 1, synchronous active-low reset.
- seq_clear, in, 1, empties the sequence (honoured in S_IDLE only).
- seq_wr_en, in, 1, appends seq_wr_dir (honoured in S_IDLE only, when not full).
- seq_wr_dir, in, 2, direction code: 00 up, 01 down, 10 right, 11 left.
- begin_signal, in, 1, starts playback (sampled in S_IDLE only).
- stop, in, 1, pauses the hold and gap counters while high.
- plot_ready, in, 1, plotter accepts the current request.
- plot_valid, out, 1, pad plot request.
- out_x, out, 8, pad origin x.
- out_y, out, 7, pad origin y.
- out_color, out, 3, plot colour.
- seq_count, out, CW, stored entry count.
- seq_full, out, 1, seq_count==SEQ_DEPTH.
- busy, out, 1, high in any state other than S_IDLE.
- done, out, 1, one-cycle pulse at the end of playback.

Behaviour:
- Pad coordinates (x,y): up (78,54), down (78,62), left (74,58), right (82,58).
- Reset values:
  - state S_INIT, init index 0, seq_count 0, counters 0.
  - plot_valid 0, out_x 0, out_y 0, out_color 0, done 0, busy 1.
- Handshake:
  - Transfer occurs when plot_valid & plot_ready are both high at a clock edge.
  - While plot_valid is high, out_x, out_y and out_color are held stable.
  - plot_valid is a registered output. It asserts on the first cycle of each plot state and deasserts on the cycle after the transfer.
- S_INIT: plots all four pads in IDLE_COLOR, in order up, down, left, right, one request per pad, then goes to S_IDLE.
- S_IDLE:
  - seq_clear has priority over seq_wr_en: sets seq_count to 0.
  - seq_wr_en with count<SEQ_DEPTH writes mem[count] and increments count.
  - seq_wr_en when full is ignored; count is unchanged.
  - begin_signal: step index set to 0. If count==0, go to S_DONE; otherwise go to S_LIGHT.
- S_LIGHT: requests the pad mem[step] in LIT_COLOR. On transfer, load the counter and go to S_HOLD.
- S_HOLD: counts HOLD_CYCLES cycles in which stop is low, then goes to S_UNLIGHT.
- S_UNLIGHT: requests the same pad in IDLE_COLOR. On transfer, go to S_GAP.
- S_GAP:
  - Counts GAP_CYCLES cycles in which stop is low.
  - Then, if step==count-1, go to S_DONE; else increment step and go to S_LIGHT.
- S_DONE: done=1 for exactly one cycle, then S_IDLE.
- Stop behaviour: stop does not stall plot states. A pending request stays valid regardless of stop.
- Busy-state inputs: seq_clear, seq_wr_en and begin_signal are ignored outside S_IDLE.
- Reset mid-operation: returns to S_INIT, clears the sequence and drops plot_valid on the next edge. The pads are redrawn in idle colour.
- Step index wrap: never reached, because step is bounded by count-1.
- Counters: CNTW = $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). Terminal count is compared at value-1, so the hold lasts exactly HOLD_CYCLES clocks.

Optional Feature:
- Macro: SIMON_TONE_EN.
- When defined:
  - Adds output tone_code [2:0].
  - tone_code = {1'b1, dir} during S_HOLD; 3'b000 otherwise; reset value 0.
- When undefined: the port is absent and there is no tone logic.

Test Plan:
- Reset, plot_ready held 1:
  - 4 requests in IDLE_COLOR: (78,54), (78,62), (74,58), (82,58).
  - Then busy=0.
- Sequence and playback, HOLD_CYCLES=4, GAP_CYCLES=2, plot_ready=1:
  - Write 00,11,10, then pulse begin_signal.
  - Expected lit/unlit plot pairs: (78,54), (74,58), (82,58).
  - Lit plots 4 clocks apart from their unlit plots.
  - done pulses once; seq_count stays 3.
- Full/empty:
  - Write SEQ_DEPTH+2 entries: seq_count=SEQ_DEPTH and seq_full=1.
  - seq_clear then begin_signal: done pulses within 2 cycles, no plots issued.
- Backpressure:
  - plot_ready low 10 cycles during S_LIGHT: plot_valid and the coordinates stay stable.
  - Hold timing starts only after the transfer.
- stop high for 5 cycles mid-hold: the lit-to-unlit interval grows to 9 clocks.
- Reset asserted during S_HOLD:
  - Next cycle plot_valid=0 and seq_count=0.
  - The S_INIT redraw follows.
  - With SIMON_TONE_EN defined, tone_code returns to 0.
